// File: rtl/adc_spi_responder.sv
// SPI responder standing in for an ADC128S: decodes the channel, reads a sample memory, returns it next frame.
// Build option: define ADC_RESP_INVERT_EN to return the complement of each fetched sample.
module adc_spi_responder #(
   parameter int SET_BITS    = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                SS_n,
   input  logic                SCLK,
   input  logic                MOSI,
   output logic                MISO,
   output logic                rd_en,
   output logic [SET_BITS+2:0] rd_addr,
   input  logic [11:0]         rd_data,
   output logic                frame_done,
   output logic                frame_err,
   output logic [2:0]          last_chnnl
);

   typedef enum logic [1:0] {IDLE, SHIFT, LOAD, CAPTURE} state_t;

   state_t               state;
   logic [SYNC_STAGES:0] ss_sync;
   logic [SYNC_STAGES:0] sclk_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                 ss_fall;
   logic                 ss_rise;
   logic                 sclk_rise;
   logic                 sclk_fall;
   logic                 mosi_bit;
   logic [15:0]          rx_shft;
   logic [14:0]          tx_shft;
   logic [11:0]          tx_hold;
   logic [11:0]          capture_data;
   logic [4:0]           bit_cnt;
   logic [SET_BITS-1:0]  set_idx;
   logic                 fall_pend;

   // Synchronizers are left unreset so a reset mid-frame sees no false SS_n edge afterwards.
   always_ff @(posedge clk) begin
      ss_sync   <= {ss_sync[SYNC_STAGES-1:0], SS_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-1:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ss_fall   <= 1'b0;
         ss_rise   <= 1'b0;
         sclk_rise <= 1'b0;
         sclk_fall <= 1'b0;
         mosi_bit  <= 1'b0;
      end else begin
         ss_fall   <= ss_sync[SYNC_STAGES] & ~ss_sync[SYNC_STAGES-1];
         ss_rise   <= ~ss_sync[SYNC_STAGES] & ss_sync[SYNC_STAGES-1];
         sclk_rise <= ~sclk_sync[SYNC_STAGES] & sclk_sync[SYNC_STAGES-1];
         sclk_fall <= sclk_sync[SYNC_STAGES] & ~sclk_sync[SYNC_STAGES-1];
         mosi_bit  <= mosi_sync[SYNC_STAGES-1];
      end
   end

`ifdef ADC_RESP_INVERT_EN
   assign capture_data = ~rd_data;
`else
   assign capture_data = rd_data;
`endif

   // MISO holds the current outgoing bit; tx_shft holds the bits still to be sent.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rx_shft    <= '0;
         tx_shft    <= '0;
         tx_hold    <= '0;
         bit_cnt    <= '0;
         set_idx    <= '0;
         fall_pend  <= 1'b0;
         MISO       <= 1'b0;
         rd_en      <= 1'b0;
         rd_addr    <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         last_chnnl <= '0;
      end else begin
         rd_en      <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (ss_fall) begin
                  state   <= SHIFT;
                  bit_cnt <= '0;
                  tx_shft <= {3'b000, tx_hold};
                  MISO    <= 1'b0;
               end
            end
            SHIFT: begin
               if (ss_rise) begin
                  MISO <= 1'b0;
                  if (bit_cnt == 5'd16) begin
                     state      <= LOAD;
                     last_chnnl <= rx_shft[13:11];
                     rd_en      <= 1'b1;
                     rd_addr    <= {set_idx, rx_shft[13:11]};
                  end else begin
                     state     <= IDLE;
                     frame_err <= 1'b1;
                  end
               end else if (sclk_rise) begin
                  rx_shft <= {rx_shft[14:0], mosi_bit};
                  if (bit_cnt != 5'd31) begin
                     bit_cnt <= bit_cnt + 5'd1;
                  end
               end else if (sclk_fall) begin
                  MISO    <= tx_shft[14];
                  tx_shft <= {tx_shft[13:0], 1'b0};
               end
            end
            LOAD: begin
               state      <= CAPTURE;
               frame_done <= 1'b1;
               fall_pend  <= ss_fall;
            end
            CAPTURE: begin
               tx_hold   <= capture_data;
               set_idx   <= set_idx + SET_BITS'(1);
               fall_pend <= 1'b0;
               MISO      <= 1'b0;
               // A new frame that started during the read goes straight to shifting the fresh sample.
               if (ss_fall || fall_pend) begin
                  state   <= SHIFT;
                  bit_cnt <= '0;
                  tx_shft <= {3'b000, capture_data};
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Scoreboard bench for adc_spi_responder: a frame-level model queues expectations, a monitor checks DUT events.
module tb_adc_spi_responder;

   localparam int SET_BITS    = 6;
   localparam int SYNC_STAGES = 2;
   localparam int HALF        = 8;
   localparam int MIN_GAP     = SYNC_STAGES + 4;
   localparam int NSETS       = 1 << SET_BITS;

   logic                clk;
   logic                rst;
   logic                SS_n;
   logic                SCLK;
   logic                MOSI;
   logic                MISO;
   logic                rd_en;
   logic [SET_BITS+2:0] rd_addr;
   logic [11:0]         rd_data;
   logic                frame_done;
   logic                frame_err;
   logic [2:0]          last_chnnl;

   typedef struct {
      bit          is_err;
      logic [31:0] miso;
      logic [8:0]  addr;
      logic [2:0]  chnnl;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] obs_q[$];
   logic [11:0] mem [0:(NSETS*8)-1];
   logic [11:0] m_hold;
   int          m_idx;
   int          checks;
   int          errors;
   bit          pend_done;
   logic [2:0]  pend_chnnl;
   exp_t        mon_e;
   logic [31:0] mon_obs;

   adc_spi_responder #(.SET_BITS(SET_BITS), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .frame_done(frame_done), .frame_err(frame_err), .last_chnnl(last_chnnl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous sample memory: data appears one clock after the read strobe.
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, want, $time);
      end
   endtask

   task automatic checkResetOutputs();
      checkOutput("rst_MISO", {31'b0, MISO}, 32'd0);
      checkOutput("rst_rd_en", {31'b0, rd_en}, 32'd0);
      checkOutput("rst_rd_addr", {23'b0, rd_addr}, 32'd0);
      checkOutput("rst_frame_done", {31'b0, frame_done}, 32'd0);
      checkOutput("rst_frame_err", {31'b0, frame_err}, 32'd0);
      checkOutput("rst_last_chnnl", {29'b0, last_chnnl}, 32'd0);
   endtask

   task automatic sclkPulse(input logic b, output logic m);
      MOSI = b;
      repeat (HALF) @(negedge clk);
      SCLK = 1'b1;
      m = MISO;
      repeat (HALF) @(negedge clk);
      SCLK = 1'b0;
   endtask

   // Frame-level reference: a good frame returns the held word and replaces it with the addressed sample.
   task automatic applyStimulus(input logic [15:0] word, input int nclk, input int gap);
      exp_t        e;
      logic [31:0] held;
      logic [31:0] cap;
      logic        m;
      int          a;
      held = {20'b0, m_hold};
      e.chnnl = word[13:11];
      if (nclk == 16) begin
         a = m_idx * 8 + int'(word[13:11]);
         e.is_err = 1'b0;
         e.miso   = held;
         e.addr   = a[8:0];
`ifdef ADC_RESP_INVERT_EN
         m_hold = ~mem[a];
`else
         m_hold = mem[a];
`endif
         m_idx = (m_idx + 1) % NSETS;
      end else begin
         e.is_err = 1'b1;
         e.addr   = '0;
         e.miso   = (nclk <= 16) ? (held >> (16 - nclk)) : (held << (nclk - 16));
      end
      exp_q.push_back(e);
      cap = '0;
      SS_n = 1'b0;
      for (int i = 0; i < nclk; i++) begin
         sclkPulse((i < 16) ? word[15 - i] : 1'b0, m);
         cap = {cap[30:0], m};
      end
      MOSI = 1'b0;
      repeat (HALF) @(negedge clk);
      SS_n = 1'b1;
      obs_q.push_back(cap);
      repeat (gap) @(negedge clk);
   endtask

   task automatic drain();
      for (int k = 0; k < 400 && exp_q.size() > 0; k++) @(negedge clk);
      if (exp_q.size() != 0) checkOutput("drain_timeout", exp_q.size(), 32'd0);
   endtask

   // Monitor: every rd_en / frame_done / frame_err is matched against the oldest queued expectation.
   always @(negedge clk) begin
      if (rst) begin
         pend_done = 1'b0;
      end else begin
         if (pend_done) begin
            checkOutput("frame_done", {31'b0, frame_done}, 32'd1);
            checkOutput("last_chnnl", {29'b0, last_chnnl}, {29'b0, pend_chnnl});
            pend_done = 1'b0;
         end else if (frame_done) begin
            checkOutput("frame_done_spurious", {31'b0, frame_done}, 32'd0);
         end
         if (rd_en) begin
            if (exp_q.size() == 0 || exp_q[0].is_err) begin
               checkOutput("rd_en_spurious", {31'b0, rd_en}, 32'd0);
               if (exp_q.size() != 0) begin
                  mon_e = exp_q.pop_front();
                  if (obs_q.size() != 0) mon_obs = obs_q.pop_front();
               end
            end else begin
               mon_e = exp_q.pop_front();
               checkOutput("rd_addr", {23'b0, rd_addr}, {23'b0, mon_e.addr});
               mon_obs = (obs_q.size() != 0) ? obs_q[0] : 32'hFFFF_FFFF;
               if (obs_q.size() != 0) obs_q.pop_front();
               checkOutput("miso_word", mon_obs, mon_e.miso);
               pend_done  = 1'b1;
               pend_chnnl = mon_e.chnnl;
            end
         end
         if (frame_err) begin
            if (exp_q.size() == 0 || !exp_q[0].is_err) begin
               checkOutput("frame_err_spurious", {31'b0, frame_err}, 32'd0);
               if (exp_q.size() != 0) begin
                  mon_e = exp_q.pop_front();
                  if (obs_q.size() != 0) mon_obs = obs_q.pop_front();
               end
            end else begin
               mon_e = exp_q.pop_front();
               mon_obs = (obs_q.size() != 0) ? obs_q[0] : 32'hFFFF_FFFF;
               if (obs_q.size() != 0) obs_q.pop_front();
               checkOutput("miso_bad_frame", mon_obs, mon_e.miso);
            end
         end
      end
   end

   initial begin
      repeat (90000) @(posedge clk);
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [15:0] w;
      logic        m;
      int          n;
      checks = 0;
      errors = 0;
      pend_done = 1'b0;
      rst  = 1'b1;
      SS_n = 1'b1;
      SCLK = 1'b0;
      MOSI = 1'b0;
      for (int i = 0; i < NSETS * 8; i++) mem[i] = 12'($urandom_range(0, 4095));
      mem[5] = 12'hABC;
      m_hold = '0;
      m_idx  = 0;

      repeat (5) @(negedge clk);
      checkResetOutputs();
      rst = 1'b0;
      repeat (4) @(negedge clk);

      applyStimulus(16'h2800, 16, MIN_GAP);
      applyStimulus(16'h0000, 16, MIN_GAP);
      applyStimulus(16'h3FFF, 10, MIN_GAP + 2);
      applyStimulus(16'h1800, 16, MIN_GAP);
      applyStimulus(16'h7FFF, 17, MIN_GAP + 2);
      applyStimulus(16'h2000, 16, MIN_GAP);

      for (int f = 0; f < 80; f++) begin
         w = 16'($urandom_range(0, 65535));
         n = 16;
         if ($urandom_range(0, 9) == 0) begin
            n = $urandom_range(1, 19);
            if (n >= 16) n++;
         end
         applyStimulus(w, n, (f % 10 < 3) ? MIN_GAP : $urandom_range(MIN_GAP, 12));
      end
      drain();

      // Reset in the middle of a frame: the remainder of the frame must be ignored silently.
      SS_n = 1'b0;
      for (int i = 0; i < 5; i++) sclkPulse(1'b1, m);
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkResetOutputs();
      end
      rst = 1'b0;
      m_hold = '0;
      m_idx  = 0;
      for (int i = 0; i < 11; i++) sclkPulse(1'b1, m);
      repeat (HALF) @(negedge clk);
      SS_n = 1'b1;
      repeat (40) @(negedge clk);

      applyStimulus(16'h3800, 16, MIN_GAP);
      applyStimulus(16'h0800, 16, MIN_GAP);
      drain();
      repeat (20) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/adc_spi_responder.md
# adc_spi_responder

Synthesizable SPI responder that emulates the ADC128S end of the A2D interface, so the A2D master can be run on silicon or FPGA without an external converter. It accepts 16-bit frames on SS_n/SCLK/MOSI, decodes the requested channel, fetches a 12-bit sample from an external sample memory, and returns it in the next frame on MISO. It sits opposite the A2D interface master, with a sample ROM/RAM behind its read port.

## Interface
- SET_BITS, 6: width of the sample-set index. The memory address is {set_idx, chnnl}, SET_BITS+3 bits.
- SYNC_STAGES, 2: synchronizer depth for SS_n, SCLK and MOSI. Minimum 2.
- clk  in  1: system clock. All logic is on the rising edge.
- rst  in  1: synchronous, active-high reset.
- SS_n  in  1: SPI slave select, active low. Asynchronous to clk.
- SCLK  in  1: SPI clock, mode 0. Asynchronous to clk.
- MOSI  in  1: master-to-responder data, MSB first.
- MISO  out  1: responder-to-master data, MSB first.
- rd_en  out  1: one-cycle sample-memory read strobe.
- rd_addr  out  SET_BITS+3: sample-memory address, {set_idx, chnnl}.
- rd_data  in  12: sample data, valid exactly one clk after rd_en.
- frame_done  out  1: one-cycle pulse when a valid frame has been processed.
- frame_err  out  1: one-cycle pulse when a frame is aborted.
- last_chnnl  out  3: channel decoded from the last valid frame.

## Operation
- Synchronize SS_n, SCLK and MOSI through SYNC_STAGES flops. Detect edges from the last two synchronized samples.
- States:
  - IDLE: SS_n high. SS_n fall → SHIFT, clear bit_cnt, load tx_shft = {4'b0000, tx_hold}.
  - SHIFT:
    - SCLK rise: rx_shft = {rx_shft[14:0], MOSI}, bit_cnt++ (saturates at 31).
    - SCLK fall: tx_shft <<= 1.
    - SS_n rise with bit_cnt==16 → LOAD.
    - SS_n rise with bit_cnt≠16 → IDLE and pulse frame_err. last_chnnl, tx_hold and set_idx are unchanged.
  - LOAD: last_chnnl = rx_shft[13:11], assert rd_en with rd_addr = {set_idx, rx_shft[13:11]} → CAPTURE.
  - CAPTURE: tx_hold = rd_data (optionally inverted, see Configuration), pulse frame_done, set_idx++ (wraps at 2^SET_BITS) → IDLE.
- MISO = tx_shft[15] while in SHIFT; 0 otherwise. MISO is never tri-stated.
- Data from frame N is returned in frame N+1. The first frame after reset returns 0x0000.
- SS_n fall while in LOAD or CAPTURE: that cycle's state work completes, then the block enters SHIFT on the next cycle with the updated tx_hold. It does not fall back to IDLE.
- Reset values: MISO=0, rd_en=0, rd_addr=0, frame_done=0, frame_err=0, last_chnnl=0, tx_hold=0, set_idx=0, state=IDLE. Reset in mid-frame abandons the frame without a frame_err pulse.

## Timing
- Input-to-edge-detect latency: SYNC_STAGES+1 clk.
- SCLK high and low phases must each be ≥ SYNC_STAGES+2 clk. The A2D master's clk/32 SCLK satisfies this.
- MISO bit 15 is valid SYNC_STAGES+2 clk after SS_n falls. The master must not sample before the first SCLK rise.
- Each MISO bit changes SYNC_STAGES+2 clk after the SCLK fall, so it is stable at the next SCLK rise.
- SS_n rise → rd_en: SYNC_STAGES+2 clk. rd_en → frame_done: 1 clk.
- SS_n high time between frames: ≥ SYNC_STAGES+4 clk.

## Configuration
- ADC_RESP_INVERT_EN defined: tx_hold = ~rd_data. This matches the ADC128S model, whose output the A2D master complements.
- ADC_RESP_INVERT_EN undefined: tx_hold = rd_data.

## Test plan
- Reset: assert rst for 3 clk during an active frame → all outputs 0, state IDLE, and no frame_err pulse.
- First frame after reset: MOSI = 0x2800 (chnnl 5), set_idx 0, mem[5] = 0xABC → MISO returns 0x0000; rd_en pulses with rd_addr = 5; frame_done pulses; last_chnnl = 5.
- Second frame, MOSI = 0x0000:
  - Without ADC_RESP_INVERT_EN → MISO returns 0x0ABC.
  - With ADC_RESP_INVERT_EN → MISO returns 0x0543.
  - In both cases rd_addr = {1, 0} = 8.
- Short frame of 10 SCLKs → frame_err pulses; no rd_en; the next frame returns the previous tx_hold unchanged.
- Long frame of 17 SCLKs → frame_err pulses; set_idx is not incremented.
- Wrap: 64 valid frames with SET_BITS = 6 → set_idx returns to 0, and the 65th frame's rd_addr = {0, chnnl}.
- Back-to-back frames with the minimum SS_n high time → every frame_done pulses; the data sequence matches memory with a one-frame lag.
